// File: rtl/reaction_pkg.sv
// Shared state encoding, constants and helper functions for the reaction_arena game core.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT     = 3'd2,
    GO       = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  localparam int REACTION_MS_W = 12;
  localparam int MS_CNT_W      = 16;

  localparam logic [REACTION_MS_W-1:0] LVL_FAST_MS = 12'd200;
  localparam logic [REACTION_MS_W-1:0] LVL_MID_MS  = 12'd350;
  localparam logic [REACTION_MS_W-1:0] LVL_SLOW_MS = 12'd500;
  localparam logic [REACTION_MS_W-1:0] MS_SAT      = 12'hFFF;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1; a non-zero state never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    if (s[0]) begin
      return {1'b0, s[15:1]} ^ LFSR_TAPS;
    end else begin
      return {1'b0, s[15:1]};
    end
  endfunction

  function automatic logic [REACTION_MS_W-1:0] sat_ms(input logic [MS_CNT_W-1:0] ms);
    if (ms > {{(MS_CNT_W-REACTION_MS_W){1'b0}}, MS_SAT}) begin
      return MS_SAT;
    end else begin
      return ms[REACTION_MS_W-1:0];
    end
  endfunction

  function automatic logic [2:0] lvl_from_ms(input logic [REACTION_MS_W-1:0] ms);
    if (ms < LVL_FAST_MS) begin
      return 3'b111;
    end else if (ms < LVL_MID_MS) begin
      return 3'b011;
    end else if (ms < LVL_SLOW_MS) begin
      return 3'b001;
    end else begin
      return 3'b000;
    end
  endfunction

endpackage

// File: rtl/reaction_arena_if.sv
// Button inputs and game outputs of reaction_arena; slave is the game core, master is its user.
interface reaction_arena_if #(
  parameter int NUM_PLAYERS = 2
);
  import reaction_pkg::*;

  logic [NUM_PLAYERS-1:0]   buttons;
  logic                     rdy_led;
  logic                     go_led;
  logic                     cooldown_led;
  logic [NUM_PLAYERS-1:0]   winner;
  logic [NUM_PLAYERS-1:0]   false_start;
  logic [REACTION_MS_W-1:0] reaction_ms;
  logic [2:0]               lvl_led;
  logic                     result_valid;

  modport master (
    output buttons,
    input  rdy_led, go_led, cooldown_led, winner, false_start, reaction_ms, lvl_led, result_valid
  );

  modport slave (
    input  buttons,
    output rdy_led, go_led, cooldown_led, winner, false_start, reaction_ms, lvl_led, result_valid
  );

endinterface

// File: rtl/reaction_input_cond.sv
// One button: 2-flop synchroniser, optional debouncer (REACTION_ARENA_DEBOUNCE_EN), rising-edge detector.
module reaction_input_cond #(
  parameter int DB_CYC = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef REACTION_ARENA_DEBOUNCE_EN
  localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;

  logic [DB_W-1:0] r_db_cnt;
  logic            r_stable;

  // Accept a new level only after it has held for DB_CYC consecutive clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DB_CYC - 1)) begin
      r_db_cnt <= '0;
      r_stable <= r_sync2;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_level = r_stable;
`else
  logic w_unused_db;
  assign w_unused_db = DB_CYC[0];
  assign w_level     = r_sync2;
`endif

  // Remember the previous level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_edge = w_level & ~r_prev;

endmodule

// File: rtl/reaction_arena.sv
// Multi-player reaction game core: random wait, GO lamp, ms timing, false starts, winner and speed bar.
// Build option: define REACTION_ARENA_DEBOUNCE_EN to debounce every button for DEBOUNCE_MS.
module reaction_arena
  import reaction_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int NUM_PLAYERS    = 2,
  parameter int WAIT_MIN_MS    = 1000,
  parameter int WAIT_SPAN_LOG2 = 11,
  parameter int TIMEOUT_MS     = 2000,
  parameter int COOLDOWN_MS    = 1500,
  parameter int DEBOUNCE_MS    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  reaction_arena_if.slave   bus
);

  localparam int DIV    = CLK_HZ / 1000;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DB_CYC = DIV * DEBOUNCE_MS;

  state_t                   r_state, w_state_nxt;
  logic [PRE_W-1:0]         r_pre;
  logic [MS_CNT_W-1:0]      r_ms, r_wait, w_wait_nxt;
  logic [15:0]              r_lfsr;
  logic                     w_tick;
  logic [NUM_PLAYERS-1:0]   w_edges, w_valid, w_pick, w_fs_all;
  logic [NUM_PLAYERS-1:0]   r_winner, w_winner_nxt, r_false_start, w_fs_nxt;
  logic [REACTION_MS_W-1:0] r_reaction_ms, w_rms_nxt;
  logic                     r_result_valid, w_rv_nxt;
  logic                     r_rdy_led, r_go_led, r_cooldown_led;
  logic [2:0]               r_lvl_led;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_cond
    reaction_input_cond #(.DB_CYC(DB_CYC)) u_cond (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (bus.buttons[gi]),
      .o_edge (w_edges[gi])
    );
  end

  assign w_tick   = (r_pre == PRE_W'(DIV - 1));
  assign w_valid  = w_edges & ~r_false_start;
  // Isolate the lowest set bit so simultaneous presses go to the lowest index.
  assign w_pick   = w_valid & (~w_valid + NUM_PLAYERS'(1));
  assign w_fs_all = r_false_start | w_edges;

  // Free-running random source for the pre-GO wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  // ms prescaler and ms counter, both restarted on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (w_state_nxt != r_state) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_ms  <= r_ms + MS_CNT_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Next state and next result values.
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    w_winner_nxt = r_winner;
    w_fs_nxt     = r_false_start;
    w_rms_nxt    = r_reaction_ms;
    w_rv_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_edges) begin
          w_state_nxt = ARM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ARM: begin
        w_winner_nxt = '0;
        w_fs_nxt     = '0;
        w_rms_nxt    = '0;
        w_wait_nxt   = MS_CNT_W'(WAIT_MIN_MS) + MS_CNT_W'(r_lfsr[WAIT_SPAN_LOG2-1:0]);
        w_state_nxt  = WAIT;
      end
      WAIT: begin
        // An edge landing on the expiry cycle is still a false start.
        w_fs_nxt = w_fs_all;
        if (&w_fs_all) begin
          w_winner_nxt = '0;
          w_rv_nxt     = 1'b1;
          w_state_nxt  = COOLDOWN;
        end else if (w_tick && ((r_ms + MS_CNT_W'(1)) >= r_wait)) begin
          w_state_nxt = GO;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      GO: begin
        if (|w_valid) begin
          w_winner_nxt = w_pick;
          w_rms_nxt    = sat_ms(r_ms);
          w_rv_nxt     = 1'b1;
          w_state_nxt  = COOLDOWN;
        end else if (w_tick && (r_ms == MS_CNT_W'(TIMEOUT_MS - 1))) begin
          w_winner_nxt = '0;
          w_rms_nxt    = sat_ms(MS_CNT_W'(TIMEOUT_MS));
          w_rv_nxt     = 1'b1;
          w_state_nxt  = COOLDOWN;
        end else begin
          w_state_nxt = GO;
        end
      end
      COOLDOWN: begin
        if (w_tick && (r_ms == MS_CNT_W'(COOLDOWN_MS - 1))) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = COOLDOWN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, results and lamps, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_wait         <= '0;
      r_winner       <= '0;
      r_false_start  <= '0;
      r_reaction_ms  <= '0;
      r_result_valid <= 1'b0;
      r_rdy_led      <= 1'b0;
      r_go_led       <= 1'b0;
      r_cooldown_led <= 1'b0;
      r_lvl_led      <= 3'b000;
    end else begin
      r_state        <= w_state_nxt;
      r_wait         <= w_wait_nxt;
      r_winner       <= w_winner_nxt;
      r_false_start  <= w_fs_nxt;
      r_reaction_ms  <= w_rms_nxt;
      r_result_valid <= w_rv_nxt;
      r_rdy_led      <= (w_state_nxt == IDLE);
      r_go_led       <= (w_state_nxt == GO);
      r_cooldown_led <= (w_state_nxt == COOLDOWN);
      r_lvl_led      <= (|w_winner_nxt) ? lvl_from_ms(w_rms_nxt) : 3'b000;
    end
  end

  assign bus.rdy_led      = r_rdy_led;
  assign bus.go_led       = r_go_led;
  assign bus.cooldown_led = r_cooldown_led;
  assign bus.winner       = r_winner;
  assign bus.false_start  = r_false_start;
  assign bus.reaction_ms  = r_reaction_ms;
  assign bus.lvl_led      = r_lvl_led;
  assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_reaction_arena.sv
// Self-checking bench for reaction_arena: table of rounds, result scoreboard, reset and timeout sequences.
module tb_reaction_arena;

  localparam int CLK_HZ    = 12000;
  localparam int NP        = 2;
  localparam int WMIN      = 20;
  localparam int WLOG2     = 4;
  localparam int TMO       = 2000;
  localparam int COOL      = 100;
  localparam int CPM       = CLK_HZ / 1000;
  localparam int WAIT_LIM  = CPM * (WMIN + (1 << WLOG2)) + 40;
  localparam int COOL_LIM  = CPM * COOL + 50;

  typedef struct {
    logic [1:0]  win;
    logic [1:0]  fs;
    logic [11:0] ms;
    logic [2:0]  lvl;
  } exp_t;

  typedef struct {
    logic [1:0]  fs_press;
    logic [1:0]  go_press;
    int          delay_ms;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic prev_rv = 1'b0;
  vec_t vecs[8];
  int   n0;
  int   n1;
  int   cnt;

  reaction_arena_if #(.NUM_PLAYERS(NP)) bus ();

  reaction_arena #(
    .CLK_HZ(CLK_HZ), .NUM_PLAYERS(NP), .WAIT_MIN_MS(WMIN), .WAIT_SPAN_LOG2(WLOG2),
    .TIMEOUT_MS(TMO), .COOLDOWN_MS(COOL), .DEBOUNCE_MS(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pre-GO wait in clocks from the press at edge p=5: 4 + CPM*(WMIN + lfsr_after_8[3:0]).
  function automatic int model_wait_cycles(input int steps);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < steps; i++) begin
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
    return 4 + CPM * (WMIN + int'(s[WLOG2-1:0]));
  endfunction

  task automatic pulse(input logic [1:0] m);
    bus.buttons = m;
    repeat (4) @(negedge clk);
    bus.buttons = '0;
    repeat (3) @(negedge clk);
  endtask

  // which: 0 rdy_led, 1 go_led, 2 cooldown_led
  task automatic wait_for(input int which, input int lim, input string name);
    int n;
    logic s;
    n = 0;
    s = 1'b0;
    while (n < lim) begin
      s = (which == 0) ? bus.rdy_led : (which == 1) ? bus.go_led : bus.cooldown_led;
      if (s) break;
      @(negedge clk);
      n++;
    end
    chk(name, int'(s), 1);
  endtask

  task automatic reset_and_measure(output int n);
    rst_n = 1'b0;
    bus.buttons = '0;
    #1;
    chk("rst_rdy", bus.rdy_led, 0);
    chk("rst_go", bus.go_led, 0);
    chk("rst_cool", bus.cooldown_led, 0);
    chk("rst_winner", bus.winner, 0);
    chk("rst_fs", bus.false_start, 0);
    chk("rst_ms", bus.reaction_ms, 0);
    chk("rst_lvl", bus.lvl_led, 0);
    chk("rst_rv", bus.result_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rdy_before_edge", bus.rdy_led, 0);
    @(negedge clk);
    chk("rdy_first_edge", bus.rdy_led, 1);
    repeat (4) @(negedge clk);
    bus.buttons = 2'b01;
    n = 0;
    while (!bus.go_led && n < WAIT_LIM) begin
      @(negedge clk);
      n++;
      if (n == 4) bus.buttons = '0;
    end
    chk("wait_cycles", n, model_wait_cycles(8));
  endtask

  task automatic finish_round(input logic [1:0] m, input int d, input exp_t e);
    exp_q.push_back(e);
    repeat (CPM * d) @(negedge clk);
    pulse(m);
    wait_for(2, 50, "to_cooldown");
    wait_for(0, COOL_LIM, "back_to_idle");
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    logic go_seen;
    wait_for(0, COOL_LIM, "idle_before_round");
    exp_q.push_back(v.e);
    pulse(2'b01);
    if (v.fs_press != 2'b00) pulse(v.fs_press);
    if (&v.fs_press) begin
      go_seen = 1'b0;
      n = 0;
      while (!bus.cooldown_led && n < WAIT_LIM) begin
        if (bus.go_led) go_seen = 1'b1;
        @(negedge clk);
        n++;
      end
      chk("allfs_cooldown", bus.cooldown_led, 1);
      chk("allfs_no_go", go_seen, 0);
      wait_for(0, COOL_LIM, "back_to_idle");
    end else begin
      wait_for(1, WAIT_LIM, "go_seen");
      repeat (CPM * v.delay_ms) @(negedge clk);
      pulse(v.go_press);
      wait_for(2, 50, "to_cooldown");
      wait_for(0, COOL_LIM, "back_to_idle");
    end
  endtask

  // Scoreboard: every result_valid pulse pops one expectation; pulses must be one clock wide.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_rv) chk("rv_width", bus.result_valid, 0);
      if (bus.result_valid) begin
        if (exp_q.size() == 0) begin
          chk("rv_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("winner", bus.winner, e.win);
          chk("false_start", bus.false_start, e.fs);
          chk("reaction_ms", bus.reaction_ms, e.ms);
          chk("lvl_led", bus.lvl_led, e.lvl);
          chk("rv_cooldown", bus.cooldown_led, 1);
        end
      end
    end
    prev_rv = bus.result_valid;
  end

  initial begin
    vecs[0] = '{2'b00, 2'b01, 180, '{2'b01, 2'b00, 12'd180, 3'b111}};
    vecs[1] = '{2'b01, 2'b11, 400, '{2'b10, 2'b01, 12'd400, 3'b001}};
    vecs[2] = '{2'b00, 2'b11, 10,  '{2'b01, 2'b00, 12'd10,  3'b111}};
    vecs[3] = '{2'b00, 2'b10, 349, '{2'b10, 2'b00, 12'd349, 3'b011}};
    vecs[4] = '{2'b10, 2'b11, 200, '{2'b01, 2'b10, 12'd200, 3'b011}};
    vecs[5] = '{2'b11, 2'b00, 0,   '{2'b00, 2'b11, 12'd0,   3'b000}};
    vecs[6] = '{2'b00, 2'b01, 500, '{2'b01, 2'b00, 12'd500, 3'b000}};
    vecs[7] = '{2'b00, 2'b10, 199, '{2'b10, 2'b00, 12'd199, 3'b111}};

    bus.buttons = '0;
    @(negedge clk);
    reset_and_measure(n0);
    finish_round(2'b10, 30, '{2'b10, 2'b00, 12'd30, 3'b111});

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // No press during GO: timeout result, then exact cooldown length.
    wait_for(0, COOL_LIM, "idle_before_timeout");
    exp_q.push_back('{2'b00, 2'b00, 12'd2000, 3'b000});
    pulse(2'b01);
    wait_for(1, WAIT_LIM, "go_seen_timeout");
    cnt = 0;
    while (!bus.cooldown_led && cnt < CPM * TMO + 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, CPM * TMO);
    cnt = 0;
    while (bus.cooldown_led && cnt < COOL_LIM) begin
      @(negedge clk);
      cnt++;
    end
    chk("cooldown_cycles", cnt, CPM * COOL);
    chk("rdy_after_cooldown", bus.rdy_led, 1);

    // Reset in the middle of GO, then the same first wait as after power-up.
    pulse(2'b01);
    wait_for(1, WAIT_LIM, "go_seen_before_reset");
    repeat (100) @(negedge clk);
    chk("go_before_reset", bus.go_led, 1);
    reset_and_measure(n1);
    chk("wait_repeat", n1, n0);
    finish_round(2'b01, 5, '{2'b01, 2'b00, 12'd5, 3'b111});

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
